// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared 1-bit adder cell sequenced LSB first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds a Sub port).

module serial_adder_ctrl_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, psum;
  logic             carry;
  logic [CW-1:0]    count;

  logic             accept, last;
  logic             ha1_s, ha1_c, bit_s, ha2_c, bit_c;
  logic [WIDTH:0]   psum_ext;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  serial_adder_ctrl_ha ha1 (.a(op_a[0]), .b(op_b[0]), .s(ha1_s), .c(ha1_c));
  serial_adder_ctrl_ha ha2 (.a(ha1_s),   .b(carry),   .s(bit_s), .c(ha2_c));
  assign bit_c = ha1_c | ha2_c;

  // Shift via a WIDTH+1 concatenation so WIDTH=1 needs no special case.
  assign psum_ext = {bit_s, psum};

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = Sub ? ~B : B;
  assign c_load = Sub ? 1'b1 : Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  assign accept = Start && (state == IDLE || state == DONE);
  assign last   = (count == LAST);
  assign Busy   = (state == RUN);
  assign Done   = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      count <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= b_load;
      psum  <= '0;
      carry <= c_load;
      count <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      psum  <= psum_ext[WIDTH:1];
      carry <= bit_c;
      count <= count + CW'(1);
      if (last) begin
        Sum  <= psum_ext[WIDTH:1];
        Cout <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random additions against an arithmetic model.
// Subtraction cases are built only when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         Sub = 1'b0;
`endif
  logic         Busy, Done, Cout;
  logic [W-1:0] Sum;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(Sub),
`endif
    .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin, sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Launch one operation from a negedge and watch it until Done (bounded).
  task automatic run_op(input logic [W-1:0] a, b, input logic cin, sb, input bit poke,
                        output logic [W-1:0] sum, output logic cout, output int lat,
                        output int busy_cnt, output bit held, output bit overlap,
                        output bit timeout);
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    @(negedge CLK);
    prev_sum = Sum; prev_cout = Cout;
    Start = 1'b1; A = a; B = b; Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    Sub = sb;
`else
    if (sb) $display("note: subtract requested but not built");
`endif
    sum = '0; cout = 1'b0; lat = -1; busy_cnt = 0; held = 1; overlap = 0; timeout = 1;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        Start = 1'b0; A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      end
      if (poke && i == 3) begin Start = 1'b1; A = 8'h01; B = 8'h01; end
      if (poke && i == 4) Start = 1'b0;
      if (Busy && Done) overlap = 1;
      if (Busy) busy_cnt++;
      if (Done) begin
        lat = i - 1; sum = Sum; cout = Cout; timeout = 0;
        break;
      end
      if (Sum !== prev_sum || Cout !== prev_cout) held = 0;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Busy, Done, Cout, Sum} !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h, want all 0", Busy, Done, Cout, Sum);
    end
    Start = 1'b1; A = 8'hAA; B = 8'h55;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_dominates: got busy=%b done=%b, want 0 0", Busy, Done);
    end
    Start = 1'b0; RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    logic [W-1:0] av [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] bv [3] = '{8'h3C, 8'h01, 8'h00};
    logic         cv [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] s; logic c; int lat, bc; bit held, ov, to;
    logic [W:0]   exp;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], cv[i], 1'b0, 0, s, c, lat, bc, held, ov, to);
      exp = model(av[i], bv[i], cv[i], 1'b0);
      checks++;
      if (to || {c, s} !== exp) begin
        errors++; $display("FAIL directed_%0d: got cout=%b sum=%h timeout=%0b, want cout=%b sum=%h", i, c, s, to, exp[W], exp[W-1:0]);
      end
      checks++;
      if (lat != W || bc != W) begin
        errors++; $display("FAIL directed_timing_%0d: got latency=%0d busy=%0d, want %0d %0d", i, lat, bc, W, W);
      end
      checks++;
      if (!held || ov) begin
        errors++; $display("FAIL directed_hold_%0d: got held=%0b overlap=%0b, want 1 0", i, held, ov);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s; logic cin, c; int lat, bc; bit held, ov, to;
    logic [W:0]   exp;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (i == 0) begin a = '1; b = '1; cin = 1'b1; end
      if (i == 1) begin a = '0; b = '0; cin = 1'b0; end
      run_op(a, b, cin, 1'b0, 0, s, c, lat, bc, held, ov, to);
      exp = model(a, b, cin, 1'b0);
      checks++;
      if (to || {c, s} !== exp || lat != W || !held || ov) begin
        errors++; $display("FAIL random_%0d: a=%h b=%h cin=%b got cout=%b sum=%h lat=%0d held=%0b ov=%0b, want cout=%b sum=%h lat=%0d",
                           i, a, b, cin, c, s, lat, held, ov, exp[W], exp[W-1:0], W);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] s; logic c; int lat, bc; bit held, ov, to;
    logic [W:0]   exp;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, s, c, lat, bc, held, ov, to);
    run_op(8'h33, 8'h44, 1'b1, 1'b0, 1, s, c, lat, bc, held, ov, to);
    exp = model(8'h33, 8'h44, 1'b1, 1'b0);
    checks++;
    if (to || {c, s} !== exp || lat != W || !held) begin
      errors++; $display("FAIL start_ignored_busy: got cout=%b sum=%h lat=%0d held=%0b, want cout=%b sum=%h lat=%0d held=1",
                         c, s, lat, held, exp[W], exp[W-1:0], W);
    end
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL no_extra_run: got busy=%b done=%b, want 0 0", Busy, Done);
    end
  endtask

  task automatic test_back_to_back();
    int last_done = -1, pulses = 0, bad_gap = 0, bad_sum = 0, overlap = 0;
    @(negedge CLK);
    Start = 1'b1; A = 8'h10; B = 8'h20; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    Sub = 1'b0;
`endif
    for (int i = 1; i <= 5 * (W + 1); i++) begin
      @(negedge CLK);
      if (Busy && Done) overlap++;
      if (Done) begin
        pulses++;
        if ({Cout, Sum} !== 9'h030) bad_sum++;
        if (last_done < 0 ? (i != W + 1) : (i - last_done != W + 1)) bad_gap++;
        last_done = i;
      end
    end
    Start = 1'b0;
    checks++;
    if (pulses != 5 || bad_gap != 0 || bad_sum != 0 || overlap != 0) begin
      errors++; $display("FAIL back_to_back: got pulses=%0d bad_gap=%0d bad_sum=%0d overlap=%0d, want 5 0 0 0", pulses, bad_gap, bad_sum, overlap);
    end
    repeat (W + 2) @(negedge CLK);
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] s; logic c; int lat, bc; bit held, ov, to;
    int  done_seen = 0;
    logic [W:0] exp;
    run_op(8'hF0, 8'h0F, 1'b1, 1'b0, 0, s, c, lat, bc, held, ov, to);
    @(negedge CLK);
    Start = 1'b1; A = 8'h77; B = 8'h11; Cin = 1'b0;
    @(negedge CLK);
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({Busy, Done, Cout, Sum} !== '0) begin
      errors++; $display("FAIL reset_abort: got busy=%b done=%b cout=%b sum=%h, want all 0", Busy, Done, Cout, Sum);
    end
    RST = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge CLK);
      if (Done || Busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL abort_quiet: got %0d busy/done cycles after abort, want 0", done_seen);
    end
    run_op(8'h81, 8'h7F, 1'b0, 1'b0, 0, s, c, lat, bc, held, ov, to);
    exp = model(8'h81, 8'h7F, 1'b0, 1'b0);
    checks++;
    if (to || {c, s} !== exp || lat != W) begin
      errors++; $display("FAIL after_abort: got cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d", c, s, lat, exp[W], exp[W-1:0], W);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] av [3] = '{8'h10, 8'h01, 8'h40};
    logic [W-1:0] bv [3] = '{8'h01, 8'h02, 8'h40};
    logic [W-1:0] a, b, s; logic cin, c; int lat, bc; bit held, ov, to;
    logic [W:0]   exp;
    for (int i = 0; i < 13; i++) begin
      if (i < 3) begin a = av[i]; b = bv[i]; end
      else begin a = W'($urandom); b = W'($urandom); end
      cin = 1'($urandom);
      run_op(a, b, cin, 1'b1, 0, s, c, lat, bc, held, ov, to);
      exp = {(a >= b), W'(a - b)};
      checks++;
      if (to || {c, s} !== exp) begin
        errors++; $display("FAIL sub_%0d: a=%h b=%h cin=%b got cout=%b sum=%h, want cout=%b sum=%h", i, a, b, cin, c, s, exp[W], exp[W-1:0]);
      end
    end
    run_op(8'h21, 8'h10, 1'b1, 1'b0, 0, s, c, lat, bc, held, ov, to);
    checks++;
    if (to || {c, s} !== 9'h032) begin
      errors++; $display("FAIL sub_off_add: got cout=%b sum=%h, want cout=0 sum=32", c, s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
